// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer
// Description : Gathers up to BEATS narrow beats into one wide word and applies
//               a per-frame {>>SLICE{}} / {<<SLICE{}} streaming reorder.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packer #(
    parameter int IN_W  = 8,
    parameter int BEATS = 3,
    parameter int SLICE = 7,
    parameter int OUT_W = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_W-1:0]                in_data,
    input  logic                           in_last,
    input  logic                           in_dir,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               out_data,
    output logic [$clog2(BEATS+1)-1:0]     out_count
);

    localparam int c_ACC_W = IN_W * BEATS;
    localparam int c_CNT_W = $clog2(BEATS + 1);

    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dir;

    logic [c_ACC_W-1:0] w_stream;
    logic [c_CNT_W-1:0] w_n;
    logic               w_dir;
    logic               w_accept;
    logic               w_end;
    logic [OUT_W-1:0]   w_fwd;
    logic [OUT_W-1:0]   w_rev;
    logic [OUT_W-1:0]   w_packed;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_end    = w_accept && (in_last || (r_cnt == c_CNT_W'(BEATS - 1)));
    assign w_n      = r_cnt + c_CNT_W'(1);
    assign w_dir    = (r_cnt == '0) ? in_dir : r_dir;

    // Accumulator contents with the current beat dropped into its slot; unused
    // slots are always zero, so the stream is left-justified for any length.
    for (genvar gs = 0; gs < BEATS; gs++) begin : g_slot
        assign w_stream[(BEATS-1-gs)*IN_W +: IN_W] =
            (r_cnt == c_CNT_W'(gs)) ? in_data : r_acc[(BEATS-1-gs)*IN_W +: IN_W];
    end

    assign w_fwd = OUT_W'(w_stream) << (OUT_W - c_ACC_W);

    // One slice-reversed candidate per frame length, OR-chained under a one-hot select.
    for (genvar gn = 1; gn <= BEATS; gn++) begin : g_len
        localparam int c_S = gn * IN_W;
        logic [OUT_W-1:0] w_rev_n;
        logic [OUT_W-1:0] w_sel;

        for (genvar gi = 0; gi < c_S; gi++) begin : g_bit
            localparam int c_K  = gi / SLICE;
            localparam int c_WK = ((c_S - c_K * SLICE) < SLICE) ? (c_S - c_K * SLICE) : SLICE;
            assign w_rev_n[OUT_W - c_K * SLICE - c_WK + (gi % SLICE)] = w_stream[c_ACC_W - c_S + gi];
        end

        if (c_S < OUT_W) begin : g_pad
            assign w_rev_n[OUT_W-c_S-1:0] = '0;
        end

        if (gn == 1) begin : g_first
            assign w_sel = (w_n == c_CNT_W'(gn)) ? w_rev_n : '0;
        end else begin : g_next
            assign w_sel = g_len[gn-1].w_sel | ((w_n == c_CNT_W'(gn)) ? w_rev_n : '0);
        end
    end

    assign w_rev    = g_len[BEATS].w_sel;
    assign w_packed = w_dir ? w_rev : w_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (w_accept) begin
                if (w_end) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_stream;
                    r_cnt <= w_n;
                    if (r_cnt == '0) begin
                        r_dir <= in_dir;
                    end
                end
            end
            // A frame end alongside a drain reloads, keeping out_valid high.
            if (w_end) begin
                out_valid <= 1'b1;
                out_data  <= w_packed;
                out_count <= w_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packer
// Description : Self-checking bench for stream_packer (table, corner cases,
//               randomized frames against a queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

    localparam int IN_W  = 8;
    localparam int BEATS = 3;
    localparam int SLICE = 7;
    localparam int OUT_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_last = 1'b0;
    logic              in_dir = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
    logic [1:0]        out_count;

    int n_checks = 0;
    int n_errors = 0;

    stream_packer #(.IN_W(IN_W), .BEATS(BEATS), .SLICE(SLICE), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: build the stream by concatenation, then append slices taken
    // from the LSB end so the first slice lands at the MSB.
    function automatic logic [OUT_W-1:0] ref_pack(input logic [7:0] b[$], input logic dir);
        longint stream = 0;
        longint res = 0;
        int s = b.size() * IN_W;
        int pos = 0;
        foreach (b[i]) stream = (stream << IN_W) | longint'(b[i]);
        if (!dir) begin
            res = stream;
        end else begin
            while (pos < s) begin
                int w = (s - pos < SLICE) ? (s - pos) : SLICE;
                longint sl = (stream >> pos) & ((64'd1 << w) - 1);
                res = (res << w) | sl;
                pos += w;
            end
        end
        return OUT_W'(res << (OUT_W - s));
    endfunction

    // Cycle-level scoreboard of the output register
    logic [7:0]       m_q[$];
    logic             m_dir = 1'b0;
    logic             m_valid = 1'b0;
    logic [OUT_W-1:0] m_data = '0;
    int               m_cnt = 0;
    int               words_out = 0;
    logic             mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_cnt   = 0;
            m_q.delete();
        end else begin
            logic rdy;
            rdy = !m_valid || out_ready;
            if (out_valid && out_ready) words_out++;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (in_valid && rdy) begin
                if (m_q.size() == 0) m_dir = in_dir;
                m_q.push_back(in_data);
                if (in_last || m_q.size() == BEATS) begin
                    m_data  = ref_pack(m_q, m_dir);
                    m_cnt   = m_q.size();
                    m_valid = 1'b1;
                    m_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mon_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid) begin
                chk("mon_out_data", 32'(out_data), 32'(m_data));
                chk("mon_out_count", 32'(out_count), 32'(m_cnt));
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic dir, input bit rnd);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_dir   = dir;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (ok) break;
        end
        if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        logic [23:0] beats;
        int          n;
        logic        last;
        logic        dir;
        logic        tog;
        logic [23:0] exp_data;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tbl[0] = '{24'h060708, 3, 1'b0, 1'b0, 1'b0, 24'h060708, 3};
        tbl[1] = '{24'h060708, 3, 1'b0, 1'b1, 1'b0, 24'h1038C0, 3};
        tbl[2] = '{24'h060708, 3, 1'b0, 1'b1, 1'b1, 24'h1038C0, 3};
        tbl[3] = '{24'h070800, 2, 1'b1, 1'b1, 1'b0, 24'h103800, 2};
        tbl[4] = '{24'h070800, 2, 1'b1, 1'b0, 1'b0, 24'h070800, 2};
        tbl[5] = '{24'hA50000, 1, 1'b1, 1'b1, 1'b0, 24'h4B0000, 1};
        tbl[6] = '{24'hA50000, 1, 1'b1, 1'b0, 1'b0, 24'hA50000, 1};
        tbl[7] = '{24'h010203, 3, 1'b1, 1'b0, 1'b1, 24'h010203, 3};

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven frames, out_ready held high
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                send_beat(tbl[k].beats[23-8*i -: 8], (i == tbl[k].n - 1) && tbl[k].last,
                          tbl[k].dir ^ (tbl[k].tog && i > 0), 1'b0);
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_data", k), 32'(out_data), 32'(tbl[k].exp_data));
            chk($sformatf("tbl%0d_count", k), 32'(out_count), 32'(tbl[k].exp_cnt));
            @(posedge clk);
            #1;
        end

        // Backpressure: stall, then drain and reload in the same cycle
        out_ready = 1'b0;
        send_beat(8'h11, 1'b0, 1'b0, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h44;
        in_last  = 1'b1;
        in_dir   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h112233);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h55;
        @(negedge clk);
        chk("bp_reload1_valid", 32'(out_valid), 32'd1);
        chk("bp_reload1_data", 32'(out_data), 32'h440000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("bp_reload2_valid", 32'(out_valid), 32'd1);
        chk("bp_reload2_data", 32'(out_data), 32'h550000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a frame
        @(posedge clk);
        #1;
        send_beat(8'hAA, 1'b0, 1'b1, 1'b0);
        send_beat(8'hBB, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        chk("rst_mid_out_count", 32'(out_count), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_beat(8'h06, 1'b0, 1'b0, 1'b0);
        send_beat(8'h07, 1'b0, 1'b0, 1'b0);
        send_beat(8'h08, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_after_valid", 32'(out_valid), 32'd1);
        chk("rst_after_data", 32'(out_data), 32'h060708);
        chk("rst_after_count", 32'(out_count), 32'd3);
        @(posedge clk);
        #1;

        // Randomized frames with random backpressure and mid-frame dir changes
        base = words_out;
        for (int f = 0; f < 300; f++) begin
            int n = $urandom_range(1, BEATS);
            for (int i = 0; i < n; i++) begin
                logic lst;
                lst = (i == n - 1) ? ((n < BEATS) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                send_beat(8'($urandom), lst, 1'($urandom_range(0, 1)), 1'b1);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_word_count", 32'(words_out - base), 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
